// File: rtl/matmul_tile_scheduler_pkg.sv
// Shared types and constants for the tiled matmul scheduler slice: FSM states,
// tile counts, job descriptor and tile-size helpers.
package systolic_array_pkg;

    localparam int unsigned SCHED_DIM_W = 8;

    typedef logic [SCHED_DIM_W-1:0] tile_cnt_t;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ISSUE     = 3'd1,
        ST_WAIT_BUSY = 3'd2,
        ST_WAIT_DONE = 3'd3,
        ST_DONE      = 3'd4
    } sched_state_t;

    typedef struct packed {
        tile_cnt_t   m_tiles;
        tile_cnt_t   k_tiles;
        tile_cnt_t   p_tiles;
        logic [31:0] x_base;
        logic [31:0] w_base;
        logic [31:0] o_base;
    } matmul_desc_t;

    function automatic logic [31:0] TILE_BYTES(input int unsigned n);
        return 32'(n * n * 32'd4);
    endfunction

    // Shift-and-add scaling by a constant tile size, so no general multiplier is built
    function automatic logic [31:0] scale_by_tile(input logic [31:0] cnt, input logic [31:0] tile_b);
        logic [31:0] acc;
        acc = 32'd0;
        for (int b = 0; b < 32; b++) begin
            if (tile_b[b]) begin
                acc = acc + (cnt << b);
            end else begin
                acc = acc;
            end
        end
        return acc;
    endfunction

endpackage

// File: rtl/matmul_tile_scheduler_if.sv
// Descriptor, control and array-side signals of the tile scheduler.
// The scheduler connects through the slave modport; controller/array use master.
interface matmul_tile_scheduler_if #(parameter int unsigned DIM_W = 8);
    logic             cfg_valid;
    logic             cfg_ready;
    logic [DIM_W-1:0] cfg_m_tiles;
    logic [DIM_W-1:0] cfg_k_tiles;
    logic [DIM_W-1:0] cfg_p_tiles;
    logic [31:0]      cfg_x_base;
    logic [31:0]      cfg_w_base;
    logic [31:0]      cfg_o_base;
    logic             abort;
    logic             stall_mul;
    logic             start_mul;
    logic [31:0]      x_addr;
    logic [31:0]      w_addr;
    logic [31:0]      o_addr;
    logic             acc_clear;
    logic             busy;
    logic             job_done;
    logic             job_err;
    logic [31:0]      perf_cycles;
    logic [31:0]      perf_tiles;

    modport slave (
        input  cfg_valid, cfg_m_tiles, cfg_k_tiles, cfg_p_tiles,
               cfg_x_base, cfg_w_base, cfg_o_base, abort, stall_mul,
        output cfg_ready, start_mul, x_addr, w_addr, o_addr, acc_clear,
               busy, job_done, job_err, perf_cycles, perf_tiles
    );

    modport master (
        output cfg_valid, cfg_m_tiles, cfg_k_tiles, cfg_p_tiles,
               cfg_x_base, cfg_w_base, cfg_o_base, abort, stall_mul,
        input  cfg_ready, start_mul, x_addr, w_addr, o_addr, acc_clear,
               busy, job_done, job_err, perf_cycles, perf_tiles
    );
endinterface

// File: rtl/matmul_tile_scheduler_tile_index_counter.sv
// Nested i (outer) / j (middle) / k (inner) tile counters for the scheduler,
// with a registered first-k flag and a combinational last-tile indication.
module tile_index_counter
    import systolic_array_pkg::*;
(
    input  logic      clk,
    input  logic      n_rst,
    input  logic      load,
    input  logic      advance,
    input  tile_cnt_t m_tiles,
    input  tile_cnt_t k_tiles,
    input  tile_cnt_t p_tiles,
    output tile_cnt_t i,
    output tile_cnt_t j,
    output tile_cnt_t k,
    output logic      k_first,
    output logic      last
);

    tile_cnt_t i_r, j_r, k_r;
    logic      k_first_r;
    logic      i_last_s, j_last_s, k_last_s;

    assign i_last_s = (i_r == (m_tiles - tile_cnt_t'(1)));
    assign j_last_s = (j_r == (p_tiles - tile_cnt_t'(1)));
    assign k_last_s = (k_r == (k_tiles - tile_cnt_t'(1)));

    // Index registers: clear on job load, step k then j then i on advance
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            i_r       <= tile_cnt_t'(0);
            j_r       <= tile_cnt_t'(0);
            k_r       <= tile_cnt_t'(0);
            k_first_r <= 1'b0;
        end else if (load) begin
            i_r       <= tile_cnt_t'(0);
            j_r       <= tile_cnt_t'(0);
            k_r       <= tile_cnt_t'(0);
            k_first_r <= 1'b1;
        end else if (advance) begin
            k_first_r <= k_last_s;
            if (!k_last_s) begin
                k_r <= k_r + tile_cnt_t'(1);
            end else begin
                k_r <= tile_cnt_t'(0);
                if (!j_last_s) begin
                    j_r <= j_r + tile_cnt_t'(1);
                end else begin
                    j_r <= tile_cnt_t'(0);
                    i_r <= i_r + tile_cnt_t'(1);
                end
            end
        end
    end

    assign i       = i_r;
    assign j       = j_r;
    assign k       = k_r;
    assign k_first = k_first_r;
    assign last    = i_last_s && j_last_s && k_last_s;

endmodule

// File: rtl/matmul_tile_scheduler.sv
// Tiled (MxK)*(KxP) matmul sequencer for the NxN systolic array: i/j/k loop,
// incremental tile addressing, abort handling. Optional counters: MATMUL_TILE_SCHED_PERF_EN.
module matmul_tile_scheduler
    import systolic_array_pkg::*;
#(
    parameter int unsigned N     = 4,
    parameter int unsigned DIM_W = SCHED_DIM_W
)
(
    input logic                    clk,
    input logic                    n_rst,
    matmul_tile_scheduler_if.slave bus
);

    localparam logic [31:0] TILE_B = TILE_BYTES(N);

    sched_state_t state_r, state_nxt_s;
    matmul_desc_t desc_r;
    logic         accept_s, advance_s, abort_exit_s, zero_dims_s, abort_hit_s;
    logic         abort_r, job_err_r;
    logic         cfg_ready_r, busy_r, start_mul_r, job_done_r;
    logic [31:0]  x_addr_r, w_addr_r, o_addr_r, x_row_r, w_col_r, w_stride_r;
    tile_cnt_t    i_s, j_s, k_s;
    logic         k_first_s, last_s, i_last_s, j_last_s, k_last_s;

    assign zero_dims_s = (bus.cfg_m_tiles == {DIM_W{1'b0}}) || (bus.cfg_k_tiles == {DIM_W{1'b0}})
                      || (bus.cfg_p_tiles == {DIM_W{1'b0}});
    assign abort_hit_s = abort_r || bus.abort;
    assign i_last_s    = (i_s == (desc_r.m_tiles - tile_cnt_t'(1)));
    assign j_last_s    = (j_s == (desc_r.p_tiles - tile_cnt_t'(1)));
    assign k_last_s    = (k_s == (desc_r.k_tiles - tile_cnt_t'(1)));

    tile_index_counter u_idx (
        .clk     (clk),
        .n_rst   (n_rst),
        .load    (accept_s),
        .advance (advance_s),
        .m_tiles (desc_r.m_tiles),
        .k_tiles (desc_r.k_tiles),
        .p_tiles (desc_r.p_tiles),
        .i       (i_s),
        .j       (j_s),
        .k       (k_s),
        .k_first (k_first_s),
        .last    (last_s)
    );

    // Next-state logic and per-cycle control strobes
    always_comb begin
        state_nxt_s  = state_r;
        accept_s     = 1'b0;
        advance_s    = 1'b0;
        abort_exit_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (bus.cfg_valid) begin
                    accept_s    = 1'b1;
                    state_nxt_s = zero_dims_s ? ST_DONE : ST_ISSUE;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_ISSUE: state_nxt_s = ST_WAIT_BUSY;
            ST_WAIT_BUSY: begin
                if (bus.stall_mul) begin
                    state_nxt_s = ST_WAIT_DONE;
                end else begin
                    state_nxt_s = ST_WAIT_BUSY;
                end
            end
            ST_WAIT_DONE: begin
                if (bus.stall_mul) begin
                    state_nxt_s = ST_WAIT_DONE;
                end else if (abort_hit_s) begin
                    abort_exit_s = 1'b1;
                    state_nxt_s  = ST_DONE;
                end else if (last_s) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    advance_s   = 1'b1;
                    state_nxt_s = ST_ISSUE;
                end
            end
            ST_DONE: state_nxt_s = ST_IDLE;
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // State register with registered status/strobe outputs decoded from next state
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state_r     <= ST_IDLE;
            cfg_ready_r <= 1'b1;
            busy_r      <= 1'b0;
            start_mul_r <= 1'b0;
            job_done_r  <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            cfg_ready_r <= (state_nxt_s == ST_IDLE);
            busy_r      <= (state_nxt_s != ST_IDLE);
            start_mul_r <= (state_nxt_s == ST_ISSUE);
            job_done_r  <= (state_nxt_s == ST_DONE);
        end
    end

    // Descriptor latch, sticky abort and job error status
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            desc_r     <= '0;
            abort_r    <= 1'b0;
            job_err_r  <= 1'b0;
            w_stride_r <= 32'd0;
        end else if (accept_s) begin
            desc_r.m_tiles <= tile_cnt_t'(bus.cfg_m_tiles);
            desc_r.k_tiles <= tile_cnt_t'(bus.cfg_k_tiles);
            desc_r.p_tiles <= tile_cnt_t'(bus.cfg_p_tiles);
            desc_r.x_base  <= bus.cfg_x_base;
            desc_r.w_base  <= bus.cfg_w_base;
            desc_r.o_base  <= bus.cfg_o_base;
            abort_r        <= 1'b0;
            job_err_r      <= zero_dims_s;
            w_stride_r     <= scale_by_tile(32'(bus.cfg_p_tiles), TILE_B);
        end else begin
            if (state_r != ST_IDLE && bus.abort) begin
                abort_r <= 1'b1;
            end
            if (abort_exit_s) begin
                job_err_r <= 1'b1;
            end
        end
    end

    // Incremental tile addresses: k steps X by one tile and W by one tile row,
    // j rewinds X to the row start, i rewinds W to its base; O steps once per output tile
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            x_addr_r <= 32'd0;
            w_addr_r <= 32'd0;
            o_addr_r <= 32'd0;
            x_row_r  <= 32'd0;
            w_col_r  <= 32'd0;
        end else if (accept_s) begin
            x_addr_r <= bus.cfg_x_base;
            w_addr_r <= bus.cfg_w_base;
            o_addr_r <= bus.cfg_o_base;
            x_row_r  <= bus.cfg_x_base;
            w_col_r  <= bus.cfg_w_base;
        end else if (advance_s) begin
            if (!k_last_s) begin
                x_addr_r <= x_addr_r + TILE_B;
                w_addr_r <= w_addr_r + w_stride_r;
            end else if (!j_last_s) begin
                x_addr_r <= x_row_r;
                w_addr_r <= w_col_r + TILE_B;
                w_col_r  <= w_col_r + TILE_B;
                o_addr_r <= o_addr_r + TILE_B;
            end else if (!i_last_s) begin
                x_addr_r <= x_addr_r + TILE_B;
                x_row_r  <= x_addr_r + TILE_B;
                w_addr_r <= desc_r.w_base;
                w_col_r  <= desc_r.w_base;
                o_addr_r <= o_addr_r + TILE_B;
            end
        end
    end

`ifdef MATMUL_TILE_SCHED_PERF_EN
    logic [31:0] perf_cycles_r, perf_tiles_r;

    // Saturating busy-cycle and issued-tile counters, cleared per job
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            perf_cycles_r <= 32'd0;
            perf_tiles_r  <= 32'd0;
        end else if (accept_s) begin
            perf_cycles_r <= 32'd0;
            perf_tiles_r  <= 32'd0;
        end else begin
            if (busy_r && perf_cycles_r != 32'hFFFF_FFFF) begin
                perf_cycles_r <= perf_cycles_r + 32'd1;
            end
            if (start_mul_r && perf_tiles_r != 32'hFFFF_FFFF) begin
                perf_tiles_r <= perf_tiles_r + 32'd1;
            end
        end
    end

    assign bus.perf_cycles = perf_cycles_r;
    assign bus.perf_tiles  = perf_tiles_r;
`else
    assign bus.perf_cycles = 32'd0;
    assign bus.perf_tiles  = 32'd0;
`endif

    assign bus.cfg_ready = cfg_ready_r;
    assign bus.busy      = busy_r;
    assign bus.start_mul = start_mul_r;
    assign bus.job_done  = job_done_r;
    assign bus.job_err   = job_err_r;
    assign bus.x_addr    = x_addr_r;
    assign bus.w_addr    = w_addr_r;
    assign bus.o_addr    = o_addr_r;
    assign bus.acc_clear = k_first_s;

endmodule

// File: tb/tb_matmul_tile_scheduler.sv
// Self-checking bench for matmul_tile_scheduler: directed and randomized jobs
// against a nested-loop address model with a randomized array-busy responder.
module tb_matmul_tile_scheduler;

    logic clk = 1'b0;
    logic n_rst = 1'b0;
    int   passed = 0;
    int   total = 0;
    int   busy_ticks = 0;

    localparam logic [31:0] TILE = 32'd64;

    always #5 clk = ~clk;

    matmul_tile_scheduler_if #(.DIM_W(8)) bus ();

    matmul_tile_scheduler #(.N(4), .DIM_W(8)) dut (
        .clk   (clk),
        .n_rst (n_rst),
        .bus   (bus)
    );

    task automatic tick;
        @(posedge clk);
        #1;
        busy_ticks++;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    task automatic check_perf(input int tiles);
`ifdef MATMUL_TILE_SCHED_PERF_EN
        check("perf_tiles", bus.perf_tiles, 32'(tiles));
        check("perf_cycles", bus.perf_cycles, 32'(busy_ticks));
`else
        check("perf_tiles_off", bus.perf_tiles, 32'd0);
        check("perf_cycles_off", bus.perf_cycles, 32'd0);
`endif
    endtask

    // abort_tile: tile index whose ISSUE cycle carries an abort pulse (-1 none)
    // rst_tile: tile index during whose busy phase n_rst is pulsed (-1 none)
    task automatic run_job(input int mt, input int kt, input int pt,
                           input logic [31:0] xb, input logic [31:0] wb, input logic [31:0] ob,
                           input int abort_tile, input int rst_tile, input bit poke_cfg);
        logic [31:0] ex[$];
        logic [31:0] ew[$];
        logic [31:0] eo[$];
        logic [31:0] ec[$];
        int          issued;
        bit          aborted;
        for (int i = 0; i < mt; i++)
            for (int j = 0; j < pt; j++)
                for (int k = 0; k < kt; k++) begin
                    ex.push_back(xb + 32'(i * kt + k) * TILE);
                    ew.push_back(wb + 32'(k * pt + j) * TILE);
                    eo.push_back(ob + 32'(i * pt + j) * TILE);
                    ec.push_back((k == 0) ? 32'd1 : 32'd0);
                end
        bus.cfg_m_tiles = 8'(mt);
        bus.cfg_k_tiles = 8'(kt);
        bus.cfg_p_tiles = 8'(pt);
        bus.cfg_x_base  = xb;
        bus.cfg_w_base  = wb;
        bus.cfg_o_base  = ob;
        bus.cfg_valid   = 1'b1;
        tick;
        bus.cfg_valid = 1'b0;
        busy_ticks = 0;
        if (ex.size() == 0) begin
            check("zero_done", 32'(bus.job_done), 32'd1);
            check("zero_err", 32'(bus.job_err), 32'd1);
            check("zero_nostart", 32'(bus.start_mul), 32'd0);
            tick;
            check("zero_ready", 32'(bus.cfg_ready), 32'd1);
            check("zero_done_pulse", 32'(bus.job_done), 32'd0);
            check_perf(0);
            return;
        end
        aborted = 1'b0;
        issued = 0;
        for (int n = 0; n < ex.size(); n++) begin
            issued = n + 1;
            check("start", 32'(bus.start_mul), 32'd1);
            check("x_addr", bus.x_addr, ex[n]);
            check("w_addr", bus.w_addr, ew[n]);
            check("o_addr", bus.o_addr, eo[n]);
            check("acc_clear", 32'(bus.acc_clear), ec[n]);
            if (n == abort_tile) bus.abort = 1'b1;
            tick;
            bus.abort = 1'b0;
            check("start_pulse", 32'(bus.start_mul), 32'd0);
            repeat ($urandom_range(0, 2)) tick;
            bus.stall_mul = 1'b1;
            tick;
            if (n == rst_tile) begin
                n_rst = 1'b0;
                bus.stall_mul = 1'b0;
                tick;
                check("rst_busy", 32'(bus.busy), 32'd0);
                check("rst_ready", 32'(bus.cfg_ready), 32'd1);
                check("rst_start", 32'(bus.start_mul), 32'd0);
                check("rst_x_addr", bus.x_addr, 32'd0);
                n_rst = 1'b1;
                return;
            end
            if (poke_cfg && n == 0) begin
                bus.cfg_valid   = 1'b1;
                bus.cfg_k_tiles = 8'd0;
                tick;
                bus.cfg_valid = 1'b0;
            end
            repeat ($urandom_range(0, 3)) tick;
            check("stable_x", bus.x_addr, ex[n]);
            bus.stall_mul = 1'b0;
            tick;
            if (n == abort_tile) aborted = 1'b1;
            if (aborted) break;
        end
        check("issued", 32'(issued), aborted ? 32'(abort_tile + 1) : 32'(ex.size()));
        check("done", 32'(bus.job_done), 32'd1);
        check("done_nostart", 32'(bus.start_mul), 32'd0);
        check("job_err", 32'(bus.job_err), aborted ? 32'd1 : 32'd0);
        tick;
        check("ready_back", 32'(bus.cfg_ready), 32'd1);
        check("busy_off", 32'(bus.busy), 32'd0);
        check("done_pulse", 32'(bus.job_done), 32'd0);
        check("err_held", 32'(bus.job_err), aborted ? 32'd1 : 32'd0);
        check("x_hold", bus.x_addr, ex[issued-1]);
        check_perf(issued);
    endtask

    initial begin
        bus.cfg_valid   = 1'b0;
        bus.cfg_m_tiles = 8'd0;
        bus.cfg_k_tiles = 8'd0;
        bus.cfg_p_tiles = 8'd0;
        bus.cfg_x_base  = 32'd0;
        bus.cfg_w_base  = 32'd0;
        bus.cfg_o_base  = 32'd0;
        bus.abort       = 1'b0;
        bus.stall_mul   = 1'b0;
        n_rst = 1'b0;
        tick;
        tick;
        check("rst_cfg_ready", 32'(bus.cfg_ready), 32'd1);
        check("rst_busy0", 32'(bus.busy), 32'd0);
        check("rst_start0", 32'(bus.start_mul), 32'd0);
        check("rst_done0", 32'(bus.job_done), 32'd0);
        check("rst_err0", 32'(bus.job_err), 32'd0);
        check("rst_x0", bus.x_addr, 32'd0);
        check("rst_acc0", 32'(bus.acc_clear), 32'd0);
        n_rst = 1'b1;
        bus.abort = 1'b1;
        tick;
        bus.abort = 1'b0;
        check("idle_abort_busy", 32'(bus.busy), 32'd0);

        run_job(1, 1, 1, 32'h0000_0000, 32'h0000_0100, 32'h0000_0200, -1, -1, 1'b0);
        run_job(2, 2, 1, 32'h0000_1000, 32'h0000_3000, 32'h0000_5000, -1, -1, 1'b1);
        run_job(1, 0, 1, 32'h0000_0040, 32'h0000_0080, 32'h0000_00C0, -1, -1, 1'b0);
        run_job(2, 2, 2, 32'h0001_0000, 32'h0002_0000, 32'h0003_0000, 2, -1, 1'b0);
        run_job(1, 1, 2, 32'h0000_0000, 32'h0000_0400, 32'hFFFF_FFC0, -1, -1, 1'b0);
        run_job(2, 2, 2, 32'h0000_8000, 32'h0000_9000, 32'h0000_A000, -1, 5, 1'b0);
        run_job(2, 3, 2, 32'h0000_2000, 32'h0000_6000, 32'h0000_C000, -1, -1, 1'b0);
        repeat (4) begin
            run_job(int'($urandom_range(1, 3)), int'($urandom_range(1, 3)), int'($urandom_range(1, 3)),
                    $urandom() & 32'hFFFF_FFC0, $urandom() & 32'hFFFF_FFC0, $urandom() & 32'hFFFF_FFC0,
                    -1, -1, 1'b0);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
